// File: rtl/cpu_clk_gen_if.sv
// Control/status bundle between the board top level and the CPU clock-enable generator.
// Parameters must match those of the cpu_clk_gen instance it is bound to.
interface cpu_clk_gen_if #(
  parameter int DIV_W   = 18,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16
) ();
  logic [1:0]         mode;
  logic [DIV_W-1:0]   div_val;
  logic [BURST_W-1:0] burst_len;
  logic               burst_start;
  logic               step_btn_n;
  logic               halt_req;
  logic               cpu_ce;
  logic               cpu_phase;
  logic               busy;
  logic               burst_done;
  logic [CNT_W-1:0]   ce_count;
  logic [2:0]         state_dbg;

  // No valid/ready pair: burst_start is a one-cycle strobe that is always accepted
  // on the rising clk edge it is high for; all other inputs are levels.
  modport master (
    output mode, div_val, burst_len, burst_start, step_btn_n, halt_req,
    input  cpu_ce, cpu_phase, busy, burst_done, ce_count, state_dbg
  );

  modport slave (
    input  mode, div_val, burst_len, burst_start, step_btn_n, halt_req,
    output cpu_ce, cpu_phase, busy, burst_done, ce_count, state_dbg
  );
endinterface

// File: rtl/cpu_clk_gen.sv
// Single-clock CPU clock-enable generator: halt / debounced step / free-run / counted burst.
// Optional macro CPU_CLK_GEN_PHASE_ALIGN_EN defers stops to cpu_phase=0 and makes one press a full cycle.
module cpu_clk_gen #(
  parameter int DIV_W      = 18,
  parameter int BURST_W    = 8,
  parameter int DEBOUNCE_W = 16,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          rst_in,
  cpu_clk_gen_if.slave bus
);

  localparam logic [1:0] M_HALT  = 2'd0;
  localparam logic [1:0] M_STEP  = 2'd1;
  localparam logic [1:0] M_RUN   = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;
  localparam logic [BURST_W-1:0] REM_ONE = 1;

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_STEP  = 3'd1,
    S_RUN   = 3'd2,
    S_BIDLE = 3'd3,
    S_BRUN  = 3'd4
  } state_t;

  function automatic state_t state_of(input logic [1:0] m);
    case (m)
      M_HALT:  state_of = S_HALT;
      M_STEP:  state_of = S_STEP;
      M_RUN:   state_of = S_RUN;
      default: state_of = S_BIDLE;
    endcase
  endfunction

  state_t state, state_n;

  logic [1:0]         mode_q;
  logic               mode_chg;
  logic               halt_eff;
  logic               phase_eff;
  logic [DIV_W-1:0]   pre_cnt;
  logic               pre_en;
  logic               cmp;
  logic [BURST_W-1:0] rem, rem_n;
  logic               ce_n, done_n;
  logic               cpu_ce_q, cpu_phase_q, busy_q, burst_done_q;
  logic [CNT_W-1:0]   ce_count_q;

  // ---------------------------------------------------------------------------
  // Push button: 2-FF synchroniser, then a counter that must see the new level
  // for 2^DEBOUNCE_W-1 cycles before the stable value follows it.
  logic                  sync1, sync2, btn_stable;
  logic [DEBOUNCE_W-1:0] db_cnt;
  logic                  db_flip, step_pulse;

  assign db_flip    = (sync2 != btn_stable) && (&db_cnt);
  assign step_pulse = db_flip && btn_stable;

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      btn_stable <= 1'b1;
      db_cnt     <= '0;
    end else begin
      sync1 <= bus.step_btn_n;
      sync2 <= sync1;
      if (sync2 == btn_stable) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        btn_stable <= sync2;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Phase the CPU will be in once any enable issued this cycle has landed.
  assign phase_eff = cpu_phase_q ^ cpu_ce_q;
  assign cmp       = (pre_cnt >= bus.div_val);

`ifdef CPU_CLK_GEN_PHASE_ALIGN_EN
  logic halt_lat;
  logic to_stop;
  logic step_arm, step_hold;
  logic arm_n, hold_n;

  assign to_stop  = (bus.mode == M_HALT) || (bus.mode == M_STEP);
  assign mode_chg = (bus.mode != mode_q) && !(to_stop && phase_eff);
  assign halt_eff = bus.halt_req && (halt_lat || !phase_eff);
`else
  assign mode_chg = (bus.mode != mode_q);
  assign halt_eff = bus.halt_req;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state <= state_of(bus.mode);
    end else begin
      state <= state_n;
    end
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    if (mode_chg) begin
      state_n = state_of(bus.mode);
    end else begin
      case (state)
        S_BIDLE, S_BRUN: begin
          if (bus.burst_start) begin
            state_n = (bus.burst_len != '0) ? S_BRUN : S_BIDLE;
          end else if (state == S_BRUN && !halt_eff && cmp && rem == REM_ONE) begin
            state_n = S_BIDLE;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // FSM: outputs and datapath controls
  always_comb begin
    pre_en = 1'b0;
    ce_n   = 1'b0;
    done_n = 1'b0;
    rem_n  = rem;
`ifdef CPU_CLK_GEN_PHASE_ALIGN_EN
    arm_n  = 1'b0;
    hold_n = 1'b0;
`endif
    if (mode_chg) begin
      rem_n = '0;
    end else begin
      case (state)
        S_RUN: begin
          pre_en = !halt_eff;
          ce_n   = !halt_eff && cmp;
        end
        S_STEP: begin
`ifdef CPU_CLK_GEN_PHASE_ALIGN_EN
          // First half-cycle follows the press directly, the second one divisor period later.
          arm_n  = step_pulse && !halt_eff;
          hold_n = step_hold;
          if (!halt_eff) begin
            if (step_arm) begin
              ce_n   = 1'b1;
              hold_n = 1'b1;
            end else if (step_hold) begin
              pre_en = 1'b1;
              if (cmp) begin
                ce_n   = 1'b1;
                hold_n = 1'b0;
              end
            end
          end
`else
          ce_n = step_pulse && !halt_eff;
`endif
        end
        S_BIDLE, S_BRUN: begin
          if (bus.burst_start) begin
            rem_n  = bus.burst_len;
            done_n = (bus.burst_len == '0);
          end else if (state == S_BRUN && !halt_eff) begin
            pre_en = 1'b1;
            if (cmp) begin
              ce_n   = 1'b1;
              rem_n  = rem - 1'b1;
              done_n = (rem == REM_ONE);
            end
          end
        end
        default: ce_n = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. The prescaler sits at 0 whenever it is not enabled.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      mode_q       <= bus.mode;
      pre_cnt      <= '0;
      rem          <= '0;
      cpu_ce_q     <= 1'b0;
      cpu_phase_q  <= 1'b0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      ce_count_q   <= '0;
    end else begin
      if (mode_chg) begin
        mode_q <= bus.mode;
      end
      pre_cnt      <= (pre_en && !cmp) ? pre_cnt + 1'b1 : '0;
      rem          <= rem_n;
      cpu_ce_q     <= ce_n;
      cpu_phase_q  <= cpu_phase_q ^ cpu_ce_q;
      busy_q       <= (state_n == S_BRUN);
      burst_done_q <= done_n;
      ce_count_q   <= ce_count_q + ce_n;
    end
  end

`ifdef CPU_CLK_GEN_PHASE_ALIGN_EN
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      halt_lat  <= 1'b0;
      step_arm  <= 1'b0;
      step_hold <= 1'b0;
    end else begin
      halt_lat  <= halt_eff;
      step_arm  <= arm_n;
      step_hold <= hold_n;
    end
  end
`endif

  // Back-to-back enables only make sense at the maximum rate.
  assert property (@(posedge clk) disable iff (!rst_in)
    (cpu_ce_q && ce_n) |-> (bus.div_val == '0));

  assign bus.cpu_ce     = cpu_ce_q;
  assign bus.cpu_phase  = cpu_phase_q;
  assign bus.busy       = busy_q;
  assign bus.burst_done = burst_done_q;
  assign bus.ce_count   = ce_count_q;
  assign bus.state_dbg  = state;

endmodule
